// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core's M stage and a DMA/debug port.
// Each access runs IDLE -> ISSUE -> WAIT -> DONE; the core is stalled until its own DONE cycle.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemReadM,
    input  logic          MemWriteM,
    input  logic [AW-1:0] DataAdrM,
    input  logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] ReadDataM,
    output logic          StallM,
    input  logic          DmaReq,
    input  logic          DmaWe,
    input  logic [AW-1:0] DmaAdr,
    input  logic [DW-1:0] DmaWData,
    output logic          DmaGnt,
    output logic          DmaDone,
    output logic [DW-1:0] DmaRData,
    output logic          MemEn,
    output logic          MemWe,
    output logic [AW-1:0] MemAdr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData
);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state_reg, state_next;
    logic          owner_reg, owner_next;       // 1 = DMA owns the access
    logic [SW-1:0] starve_reg, starve_next;
    logic [LW-1:0] lat_reg, lat_next;
    logic          we_reg, we_next;
    logic [AW-1:0] adr_reg, adr_next;
    logic [DW-1:0] wdata_reg, wdata_next;
    logic [DW-1:0] core_rdata_reg, core_rdata_next;
    logic [DW-1:0] dma_rdata_reg, dma_rdata_next;

    logic core_req;
    logic dma_win;
    logic core_done;

    assign core_req  = MemReadM | MemWriteM;
    // DMA takes the slot when the core is idle or once the core has starved it long enough
    assign dma_win   = DmaReq & (~core_req | (starve_reg == SW'(STARVE_MAX)));
    assign core_done = (state_reg == DONE) & ~owner_reg;

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        starve_next     = starve_reg;
        lat_next        = lat_reg;
        we_next         = we_reg;
        adr_next        = adr_reg;
        wdata_next      = wdata_reg;
        core_rdata_next = core_rdata_reg;
        dma_rdata_next  = dma_rdata_reg;
        case (state_reg)
            IDLE: begin
                if (!DmaReq) begin
                    starve_next = '0;
                end
                if (dma_win) begin
                    owner_next  = 1'b1;
                    starve_next = '0;
                    we_next     = DmaWe;
                    adr_next    = DmaAdr;
                    wdata_next  = DmaWData;
                    state_next  = ISSUE;
                end else if (core_req) begin
                    owner_next = 1'b0;
                    we_next    = MemWriteM;   // read+write together counts as a write
                    adr_next   = DataAdrM;
                    wdata_next = WriteDataM;
                    state_next = ISSUE;
                    if (DmaReq && (starve_reg != SW'(STARVE_MAX))) begin
                        starve_next = starve_reg + SW'(1);
                    end
                end
            end
            ISSUE: begin
                if (MEM_LAT == 1) begin
                    state_next = DONE;
                end else begin
                    lat_next   = LW'(MEM_LAT - 1);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (lat_reg == LW'(1)) begin
                    state_next = DONE;
                end else begin
                    lat_next = lat_reg - LW'(1);
                end
            end
            DONE: begin
                if (!we_reg) begin
                    if (owner_reg) begin
                        dma_rdata_next = MemRData;
                    end else begin
                        core_rdata_next = MemRData;
                    end
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            starve_reg     <= '0;
            lat_reg        <= '0;
            we_reg         <= 1'b0;
            adr_reg        <= '0;
            wdata_reg      <= '0;
            core_rdata_reg <= '0;
            dma_rdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            starve_reg     <= starve_next;
            lat_reg        <= lat_next;
            we_reg         <= we_next;
            adr_reg        <= adr_next;
            wdata_reg      <= wdata_next;
            core_rdata_reg <= core_rdata_next;
            dma_rdata_reg  <= dma_rdata_next;
        end
    end

    assign MemEn    = (state_reg == ISSUE);
    assign MemWe    = MemEn & we_reg;
    assign MemAdr   = adr_reg;
    assign MemWData = wdata_reg;
    assign DmaGnt   = MemEn & owner_reg;
    assign DmaDone  = (state_reg == DONE) & owner_reg;

    // Read data is forwarded in the DONE cycle itself, then held from the capture register
    assign ReadDataM = (core_done & ~we_reg) ? MemRData : core_rdata_reg;
    assign DmaRData  = (DmaDone & ~we_reg) ? MemRData : dma_rdata_reg;
    assign StallM    = reset & core_req & ~core_done;
endmodule
